// File: rtl/prom_dl_sync.sv
// Parametrised synchronous PROM: cleared after reset, then loaded from the byte-wide download stream.
// Optional second output register stage when PROM_OUTREG_EN is defined (read latency 2).
module prom_dl_sync #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  output logic [DW-1:0] dout,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  output logic          ready,
  output logic [15:0]   checksum
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic {INIT, READY} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [15:0]   checksum_q, checksum_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] dout1_q;

  logic [DW-1:0] mem [DEPTH];

  logic          we_c;
  logic [AW-1:0] waddr_c;
  logic [DW-1:0] wdata_c;

  // Only the low DW bits of a download byte are stored and summed.
  logic unused_dl_hi;
  assign unused_dl_hi = ^dl_data;

  // Next-state and shared write-port mux (clear path vs download path).
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    checksum_d = checksum_q;
    we_c       = 1'b0;
    waddr_c    = dl_addr;
    wdata_c    = dl_data[DW-1:0];
    unique case (state_q)
      INIT: begin
        we_c      = 1'b1;
        waddr_c   = clr_idx_q;
        wdata_c   = '0;
        clr_idx_d = clr_idx_q + AW'(1);
        if (&clr_idx_q) state_d = READY;
      end
      READY: begin
        if (dl_wr) begin
          we_c       = 1'b1;
          checksum_d = checksum_q + 16'(dl_data[DW-1:0]);
        end
      end
      default: state_d = INIT;
    endcase
    if (reset) we_c = 1'b0;
    ready_d = (state_d == READY);
  end

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_c) mem[waddr_c] <= wdata_c;
  end

  // Control registers and first output stage (read-first against the write port).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      clr_idx_q  <= '0;
      checksum_q <= '0;
      ready_q    <= 1'b0;
      dout1_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      checksum_q <= checksum_d;
      ready_q    <= ready_d;
      if (state_q == INIT) dout1_q <= '0;
      else if (cs)         dout1_q <= mem[addr];
    end
  end

`ifdef PROM_OUTREG_EN
  logic          cs_dly_q;
  logic [DW-1:0] dout2_q;

  // Second stage, enabled by cs delayed one cycle and forced to 0 until ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_dly_q <= 1'b0;
      dout2_q  <= '0;
    end else begin
      cs_dly_q <= cs;
      if (!ready_q)      dout2_q <= '0;
      else if (cs_dly_q) dout2_q <= dout1_q;
    end
  end

  assign dout = dout2_q;
`else
  assign dout = dout1_q;
`endif

  assign ready    = ready_q;
  assign checksum = checksum_q;

endmodule

// File: tb/tb_prom_dl_sync.sv
// Directed self-checking bench for prom_dl_sync (AW=8, DW=4, single output stage).
module tb_prom_dl_sync;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 4;

  logic          clk;
  logic          reset;
  logic [AW-1:0] addr;
  logic          cs;
  logic [DW-1:0] dout;
  logic          dl_wr;
  logic [AW-1:0] dl_addr;
  logic [7:0]    dl_data;
  logic          ready;
  logic [15:0]   checksum;

  int n_cmp;
  int n_fail;

  prom_dl_sync #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .cs       (cs),
    .dout     (dout),
    .dl_wr    (dl_wr),
    .dl_addr  (dl_addr),
    .dl_data  (dl_data),
    .ready    (ready),
    .checksum (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       rd;
    logic [7:0] raddr;
    logic [3:0] exp_dout;
    logic [15:0] exp_cks;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, sample #1 after the rising edge.
  task automatic step(input logic wr, input logic [7:0] wa, input logic [7:0] wd,
                      input logic rd, input logic [7:0] ra);
    @(negedge clk);
    dl_wr = wr; dl_addr = wa; dl_data = wd; cs = rd; addr = ra;
    @(posedge clk);
    #1;
  endtask

  // Counts rising edges until ready; also records any nonzero dout seen while waiting.
  task automatic wait_ready(output int cycles, output logic dout_seen);
    cycles    = 0;
    dout_seen = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) dl_wr = 1'b0;
      if (dout !== '0) dout_seen = 1'b1;
      if (ready === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ready", 16'(ready), 16'h0);
    check("reset_cks", checksum, 16'h0);
    check("reset_dout", 16'(dout), 16'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vecs[18];
  int   cyc;
  logic seen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b0; cs = 1'b0; addr = '0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;

    //          wr    waddr  wdata  rd    raddr  dout  cks
    vecs[0]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h07, 4'h0, 16'h0000};
    vecs[1]  = '{1'b1, 8'h07, 8'h01, 1'b0, 8'h00, 4'h0, 16'h0001};
    vecs[2]  = '{1'b1, 8'h16, 8'hFB, 1'b0, 8'h00, 4'h0, 16'h000C};
    vecs[3]  = '{1'b1, 8'h45, 8'h0F, 1'b0, 8'h00, 4'h0, 16'h001B};
    vecs[4]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h07, 4'h1, 16'h001B};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h16, 4'hB, 16'h001B};
    vecs[6]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h45, 4'hF, 16'h001B};
    vecs[7]  = '{1'b1, 8'h45, 8'h02, 1'b1, 8'h45, 4'hF, 16'h001D};
    vecs[8]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h45, 4'h2, 16'h001D};
    vecs[9]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h07, 4'h1, 16'h001D};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h16, 4'h1, 16'h001D};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h16, 4'hB, 16'h001D};
    vecs[12] = '{1'b1, 8'h30, 8'h05, 1'b0, 8'h16, 4'hB, 16'h0022};
    vecs[13] = '{1'b1, 8'h30, 8'h0A, 1'b0, 8'h16, 4'hB, 16'h002C};
    vecs[14] = '{1'b1, 8'h31, 8'hFF, 1'b1, 8'h30, 4'hA, 16'h003B};
    vecs[15] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h31, 4'hF, 16'h003B};
    vecs[16] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 4'h0, 16'h003B};
    vecs[17] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 4'h0, 16'h003B};

    // Reset, then a download attempt during INIT that must be ignored.
    pulse_reset();
    dl_wr = 1'b1; dl_addr = 8'h07; dl_data = 8'h01; cs = 1'b1; addr = 8'h07;
    wait_ready(cyc, seen);
    check("init_ready_cycles", 16'(cyc), 16'd256);
    check("init_dout_zero", 16'(seen), 16'h0);
    check("init_cks_ignored", checksum, 16'h0);

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].wr, vecs[i].waddr, vecs[i].wdata, vecs[i].rd, vecs[i].raddr);
      check($sformatf("vec%0d_dout", i), 16'(dout), 16'(vecs[i].exp_dout));
      check($sformatf("vec%0d_cks", i), checksum, vecs[i].exp_cks);
      check($sformatf("vec%0d_ready", i), 16'(ready), 16'h1);
    end

    // Ten downloads of 1..10 to 0x50.., then reset mid-stream with a write pending.
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h50 + i), 8'(i + 1), 1'b0, 8'h00);
    check("dl10_cks", checksum, 16'h003B + 16'd55);
    step(1'b1, 8'h5A, 8'h07, 1'b1, 8'h50);
    check("dl10_read", 16'(dout), 16'h1);
    pulse_reset();
    dl_wr = 1'b0; cs = 1'b1; addr = 8'h50;
    wait_ready(cyc, seen);
    check("reclear_ready_cycles", 16'(cyc), 16'd256);
    check("reclear_dout_zero", 16'(seen), 16'h0);
    check("reclear_cks", checksum, 16'h0);
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b1, 8'(8'h50 + i));
      check($sformatf("reclear_rd%0d", i), 16'(dout), 16'h0);
    end
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'h45);
    check("reclear_rd45", 16'(dout), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
